serial_magnitude_comparator: RTL and testbench

- Multi-cycle, MSB-first bit-serial magnitude comparator for WIDTH-bit operands, with signed/unsigned mode and optional early termination.
- Iterates the 2-bit (p,q) "decided" state one bit per clock, generalising the combinational 1-bit comparator slice into a parametrised sequential unit.
- Used by datapath/ALU control that can tolerate multi-cycle latency in exchange for minimal comparator area.
- Start/done handshake; result held until the next start.

---
 rtl/comparator_pkg.sv | 15 +
 rtl/comparator_slice.sv | 26 ++
 rtl/serial_magnitude_comparator.sv | 118 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// FSM state encoding and (p,q) decided-state constants.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] PQ_EQ = 2'b00;
  localparam logic [1:0] PQ_GT = 2'b10;
  localparam logic [1:0] PQ_LT = 2'b01;

endpackage

// File: rtl/comparator_slice.sv
// One-bit comparator slice with sticky decided state.
// Once (p,q) leaves "equal so far" it never changes again.
module comparator_slice
  import comparator_pkg::*;
(
  input  logic p,
  input  logic q,
  input  logic a_i,
  input  logic b_i,
  output logic p_next,
  output logic q_next
);

  // Decide on the first differing bit, otherwise hold
  always_comb begin
    {p_next, q_next} = {p, q};
    if ({p, q} == PQ_EQ) begin
      unique case (1'b1)
        (a_i & ~b_i): {p_next, q_next} = PQ_GT;
        (~a_i & b_i): {p_next, q_next} = PQ_LT;
        default:      {p_next, q_next} = PQ_EQ;
      endcase
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial magnitude comparator, signed/unsigned.
// One slice step per clock; result held until the next accept.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [1:0]       r_pq;
  logic [IW-1:0]    r_idx;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic             w_swap;
  logic             w_ai;
  logic             w_bi;
  logic             w_pn;
  logic             w_qn;
  logic [1:0]       w_pq_n;
  logic             w_fin;
  logic             w_accept;

  // In signed mode the sign bits are swapped: a set MSB means smaller
  assign w_swap   = r_sgn & (r_idx == IDX_TOP);
  assign w_ai     = w_swap ? r_b[r_idx] : r_a[r_idx];
  assign w_bi     = w_swap ? r_a[r_idx] : r_b[r_idx];
  assign w_pq_n   = {w_pn, w_qn};
  assign w_fin    = (r_idx == '0) |
                    (EARLY_EXIT & (w_pq_n != PQ_EQ));
  assign w_accept = start & (r_state != CMP);

  comparator_slice u_slice (
    .p      (r_pq[1]),
    .q      (r_pq[0]),
    .a_i    (w_ai),
    .b_i    (w_bi),
    .p_next (w_pn),
    .q_next (w_qn)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; DONE accepts a new start like IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CMP;
      CMP:     if (w_fin) w_next = DONE;
      DONE:    w_next = start ? CMP : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, bit scan and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_pq  <= PQ_EQ;
      r_idx <= IDX_TOP;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_sgn <= signed_mode;
      r_pq  <= PQ_EQ;
      r_idx <= IDX_TOP;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else if (r_state == CMP) begin
      r_pq <= w_pq_n;
      if (w_fin) begin
        r_gt <= w_pn & ~w_qn;
        r_lt <= ~w_pn & w_qn;
        r_eq <= ~w_pn & ~w_qn;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign busy = (r_state == CMP);
  assign done = (r_state == DONE);
  assign gt   = r_gt;
  assign lt   = r_lt;
  assign eq   = r_eq;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for the serial magnitude comparator.
// Instance 0 scans all bits, instance 1 exits early.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   st;
  logic [1:0]   sg;
  logic [W-1:0] av [2];
  logic [W-1:0] bv [2];
  logic [1:0]   busy;
  logic [1:0]   done;
  logic [1:0]   gt;
  logic [1:0]   lt;
  logic [1:0]   eq;

  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0;
  exp_t m1;

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clock(clock), .reset(reset), .start(st[0]),
    .a(av[0]), .b(bv[0]), .signed_mode(sg[0]),
    .busy(busy[0]), .done(done[0]),
    .gt(gt[0]), .lt(lt[0]), .eq(eq[0])
  );

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clock(clock), .reset(reset), .start(st[1]),
    .a(av[1]), .b(bv[1]), .signed_mode(sg[1]),
    .busy(busy[1]), .done(done[1]),
    .gt(gt[1]), .lt(lt[1]), .eq(eq[1])
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer compare, latency from first differing bit
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic s, bit ee, int e0);
    exp_t e;
    logic [W-1:0] x;
    int msb;
    int k;
    logic g, l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    e.res = {g, l, (a == b)};
    x = a ^ b;
    msb = -1;
    for (int i = 0; i < W; i++) if (x[i]) msb = i;
    k = W;
    if (ee && msb >= 0) k = W - msb;
    e.cyc = e0 + k;
    return e;
  endfunction

  // Monitor for the full-scan instance
  always @(negedge clock) begin
    if (done[0]) begin
      if (q0.size() == 0) begin
        check("unexpected_done0", 1, 0);
      end else begin
        m0 = q0.pop_front();
        check("result0", {gt[0], lt[0], eq[0]}, m0.res);
        check("latency0", cyc, m0.cyc);
      end
    end
  end

  // Monitor for the early-exit instance
  always @(negedge clock) begin
    if (done[1]) begin
      if (q1.size() == 0) begin
        check("unexpected_done1", 1, 0);
      end else begin
        m1 = q1.pop_front();
        check("result1", {gt[1], lt[1], eq[1]}, m1.res);
        check("latency1", cyc, m1.cyc);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge
  task automatic issue(int d, logic [W-1:0] a, logic [W-1:0] b,
                       logic s, bit push);
    exp_t e;
    av[d] = a;
    bv[d] = b;
    sg[d] = s;
    st[d] = 1'b1;
    e = model(a, b, s, (d == 1), cyc + 1);
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clock);
    st[d] = 1'b0;
  endtask

  task automatic wait_idle(int d, int explen, bit rnd);
    int n;
    n = 0;
    while (busy[d] && n < 100) begin
      n++;
      if (rnd) begin
        av[d] = W'($urandom);
        bv[d] = W'($urandom);
        sg[d] = 1'($urandom);
        st[d] = 1'($urandom);
      end
      @(negedge clock);
    end
    st[d] = 1'b0;
    check("busy_cycles", n, explen);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t  e;
    int    t1;
    int    lat;
    int    n;
    logic [W-1:0] ra, rb;
    logic  rs;
    int    d;

    reset = 1'b1;
    st    = '0;
    sg    = '0;
    av[0] = '0; av[1] = '0;
    bv[0] = '0; bv[1] = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", {gt, lt, eq}, 0);
    reset = 1'b0;
    @(negedge clock);

    issue(0, 8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_idle(0, 8, 1'b0);
    issue(0, 8'h80, 8'h7F, 1'b0, 1'b1);
    wait_idle(0, 8, 1'b0);
    issue(0, 8'h80, 8'h7F, 1'b1, 1'b1);
    wait_idle(0, 8, 1'b0);
    issue(0, 8'hFF, 8'hFE, 1'b1, 1'b1);
    wait_idle(0, 8, 1'b0);

    issue(1, 8'h80, 8'h00, 1'b0, 1'b1);
    wait_idle(1, 1, 1'b0);
    issue(1, 8'h03, 8'h02, 1'b0, 1'b1);
    wait_idle(1, 8, 1'b0);
    repeat (3) @(negedge clock);
    check("held_gt", {gt[1], lt[1], eq[1]}, 3'b100);

    // start during CMP is ignored
    issue(0, 8'h10, 8'h20, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    av[0] = 8'hFF;
    bv[0] = 8'h00;
    st[0] = 1'b1;
    @(negedge clock);
    st[0] = 1'b0;
    wait_idle(0, 5, 1'b0);

    // reset in the fourth CMP cycle aborts with no done
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", busy[0], 0);
    check("abort_done", done[0], 0);
    check("abort_res", {gt[0], lt[0], eq[0]}, 0);
    repeat (12) @(negedge clock);
    check("abort_idle", busy[0], 0);

    // start held through DONE: back-to-back accept
    issue(1, 8'h37, 8'h35, 1'b0, 1'b1);
    t1 = model(8'h37, 8'h35, 1'b0, 1'b1, cyc).cyc;
    av[1] = 8'h01;
    bv[1] = 8'h02;
    sg[1] = 1'b0;
    st[1] = 1'b1;
    e = model(8'h01, 8'h02, 1'b0, 1'b1, t1 + 1);
    q1.push_back(e);
    n = 0;
    while (cyc != t1 + 1 && n < 50) begin
      n++;
      @(negedge clock);
    end
    st[1] = 1'b0;
    check("b2b_busy", busy[1], 1);
    check("b2b_clear", {gt[1], lt[1], eq[1]}, 0);
    wait_idle(1, e.cyc - (t1 + 1), 1'b0);

    // randomized traffic on both instances
    for (int i = 0; i < 80; i++) begin
      d  = i % 2;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      else if ($urandom_range(0, 2) == 0)
        rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      lat = model(ra, rb, rs, (d == 1), 0).cyc;
      issue(d, ra, rb, rs, 1'b1);
      wait_idle(d, lat, 1'b1);
    end

    repeat (3) @(negedge clock);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
